// File: rtl/pc_sequencer_pkg.sv
// Shared types and widths for the program-counter sequencer slice.
package pc_seq_pkg;

  localparam int unsigned PC_W  = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Start addresses indexed by prog_sel.
  typedef logic [3:0][PC_W-1:0] start_tbl_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Handshake, branch-LUT and status bundle between the bench side and the sequencer.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic             start;
  logic [1:0]       prog_sel;
  logic             stall;
  logic             halt;
  logic             branch_en;
  logic             branch_taken;
  logic [IDX_W-1:0] branch_idx;
  logic [PC_W-1:0]  lut_target;
  logic [IDX_W-1:0] lut_index;
  logic [PC_W-1:0]  pc;
  logic             fetch_valid;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, prog_sel, stall, halt, branch_en, branch_taken, branch_idx, lut_target,
    input  lut_index, pc, fetch_valid, busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, prog_sel, stall, halt, branch_en, branch_taken, branch_idx, lut_target,
    output lut_index, pc, fetch_valid, busy, done, timeout, cycle_count
  );

endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: start/done handshake, next-PC select and watchdog.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0]  START0   = 8'h00,
  parameter logic [PC_W-1:0]  START1   = 8'h40,
  parameter logic [PC_W-1:0]  START2   = 8'h80,
  parameter logic [PC_W-1:0]  START3   = 8'hC0,
  parameter logic [CNT_W-1:0] WATCHDOG = 16'hFFFF
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  state_t           state;
  logic [PC_W-1:0]  pc_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             wd_hit;
  start_tbl_t       starts;

  assign starts = {START3, START2, START1, START0};
  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign wd_hit = (state == RUN) && (cnt_q == (WATCHDOG - CNT_W'(1)));

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (state == RUN),
    .q     (cnt_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            pc_q      <= starts[bus.prog_sel];
            timeout_q <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (!bus.start) state <= RUN;
        end
        RUN: begin
          // Watchdog beats stall, stall beats halt and branch.
          if (wd_hit) begin
            timeout_q <= 1'b1;
            state     <= DONE;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (bus.halt) begin
            state <= DONE;
          end else if (bus.branch_en && bus.branch_taken) begin
            pc_q <= bus.lut_target;
          end else begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cnt_q;
  assign bus.fetch_valid = (state == RUN);
  assign bus.busy        = (state == LOAD) || (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.lut_index   = (state == RUN) ? bus.branch_idx : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (watchdog shortened to 20 cycles).
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.WATCHDOG(16'd20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.prog_sel     = 2'd0;
    bus.stall        = 1'b0;
    bus.halt         = 1'b0;
    bus.branch_en    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_idx   = '0;
    bus.lut_target   = '0;

    #12;
    chk("rst_pc", 32'(bus.pc), 32'h00);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fv", 32'(bus.fetch_valid), 32'd0);
    chk("rst_cnt", 32'(bus.cycle_count), 32'd0);
    chk("rst_to", 32'(bus.timeout), 32'd0);

    // Start program 1, hold start for two edges.
    reset = 1'b0;
    bus.prog_sel = 2'd1;
    bus.start = 1'b1;
    tick();
    chk("load_pc", 32'(bus.pc), 32'h40);
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_fv", 32'(bus.fetch_valid), 32'd0);
    tick();
    chk("load_hold_pc", 32'(bus.pc), 32'h40);
    chk("load_hold_fv", 32'(bus.fetch_valid), 32'd0);
    bus.start = 1'b0;
    tick();
    chk("run_pc0", 32'(bus.pc), 32'h40);
    chk("run_fv", 32'(bus.fetch_valid), 32'd1);
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_done", 32'(bus.done), 32'd0);
    tick();
    chk("run_pc1", 32'(bus.pc), 32'h41);
    tick();
    chk("run_pc2", 32'(bus.pc), 32'h42);
    chk("run_cnt2", 32'(bus.cycle_count), 32'd2);

    // Branch taken / not taken.
    bus.branch_en = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_idx = 4'h3;
    bus.lut_target = 8'h45;
    #1;
    chk("lut_idx_run", 32'(bus.lut_index), 32'h3);
    tick();
    chk("br_to_45", 32'(bus.pc), 32'h45);
    bus.lut_target = 8'h20;
    tick();
    chk("br_taken", 32'(bus.pc), 32'h20);
    bus.lut_target = 8'h45;
    tick();
    chk("br_back_45", 32'(bus.pc), 32'h45);
    bus.branch_taken = 1'b0;
    bus.lut_target = 8'h20;
    tick();
    chk("br_not_taken", 32'(bus.pc), 32'h46);

    // Wrap, stall-over-halt, then halt.
    bus.branch_taken = 1'b1;
    bus.lut_target = 8'hFF;
    tick();
    chk("br_to_ff", 32'(bus.pc), 32'hFF);
    bus.branch_en = 1'b0;
    bus.branch_taken = 1'b0;
    tick();
    chk("pc_wrap", 32'(bus.pc), 32'h00);
    bus.stall = 1'b1;
    bus.halt = 1'b1;
    tick();
    chk("stall_pc", 32'(bus.pc), 32'h00);
    chk("stall_fv", 32'(bus.fetch_valid), 32'd1);
    chk("stall_done", 32'(bus.done), 32'd0);
    bus.stall = 1'b0;
    tick();
    chk("halt_done", 32'(bus.done), 32'd1);
    chk("halt_busy", 32'(bus.busy), 32'd0);
    chk("halt_pc", 32'(bus.pc), 32'h00);
    chk("halt_fv", 32'(bus.fetch_valid), 32'd0);
    chk("halt_cnt", 32'(bus.cycle_count), 32'd10);
    #1;
    chk("lut_idx_done", 32'(bus.lut_index), 32'h0);
    bus.halt = 1'b0;

    // Program 0 with stalls on RUN cycles 3, 4 and 7.
    bus.prog_sel = 2'd0;
    bus.start = 1'b1;
    tick();
    chk("p0_load_pc", 32'(bus.pc), 32'h00);
    chk("p0_cnt_clr", 32'(bus.cycle_count), 32'd0);
    bus.start = 1'b0;
    tick();
    for (int i = 1; i <= 10; i++) begin
      bus.stall = (i == 3) || (i == 4) || (i == 7);
      tick();
    end
    bus.stall = 1'b0;
    chk("p0_pc", 32'(bus.pc), 32'h07);
    chk("p0_cnt10", 32'(bus.cycle_count), 32'd10);
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    tick();
    chk("p0_done", 32'(bus.done), 32'd1);
    chk("p0_cnt11", 32'(bus.cycle_count), 32'd11);
    chk("p0_pc_hold", 32'(bus.pc), 32'h07);

    // Restart from DONE with program 2, then let the watchdog fire.
    bus.prog_sel = 2'd2;
    bus.start = 1'b1;
    tick();
    chk("p2_pc", 32'(bus.pc), 32'h80);
    chk("p2_cnt_clr", 32'(bus.cycle_count), 32'd0);
    chk("p2_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    tick();
    for (int i = 0; i < 19; i++) tick();
    chk("wd_pre_fv", 32'(bus.fetch_valid), 32'd1);
    chk("wd_pre_to", 32'(bus.timeout), 32'd0);
    chk("wd_pre_cnt", 32'(bus.cycle_count), 32'd19);
    tick();
    chk("wd_done", 32'(bus.done), 32'd1);
    chk("wd_to", 32'(bus.timeout), 32'd1);
    chk("wd_cnt", 32'(bus.cycle_count), 32'd20);
    chk("wd_pc", 32'(bus.pc), 32'h93);
    tick();
    chk("wd_to_hold", 32'(bus.timeout), 32'd1);
    bus.prog_sel = 2'd3;
    bus.start = 1'b1;
    tick();
    chk("restart_to_clr", 32'(bus.timeout), 32'd0);
    chk("p3_pc", 32'(bus.pc), 32'hC0);
    bus.start = 1'b0;
    tick();

    // Asynchronous reset in the middle of RUN.
    bus.branch_en = 1'b1;
    bus.branch_taken = 1'b1;
    bus.lut_target = 8'h57;
    tick();
    chk("pre_rst_pc", 32'(bus.pc), 32'h57);
    bus.branch_en = 1'b0;
    bus.branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", 32'(bus.pc), 32'h00);
    chk("arst_fv", 32'(bus.fetch_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_cnt", 32'(bus.cycle_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
